par_frame_gen: RTL and testbench
================================

PAR_FRAME_GEN -- requirements
Module: par_frame_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 8, payload width in bits; legal range 2..32.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/odd_sel are valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  payload word.
- odd_sel  input  1  parity mode for this word: 0 = even, 1 = odd.
- ser_out  output  1  serial bit stream.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- ser_is_par  output  1  the current ser_out bit is the parity bit.
- frame_done  output  1  single-cycle pulse on the last bit of a frame.
REQ-003 The block SHALL use one clock (clk); reset SHALL be asynchronous and active-low (rst_n).

Function
REQ-004 The block SHALL implement the FSM states IDLE, SHIFT and PARITY.
REQ-005 A word SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1.
REQ-006 in_ready SHALL be 1 in IDLE and in PARITY, and 0 in SHIFT.
REQ-007 On acceptance, the block SHALL capture in_data into a shift register.
REQ-008 On acceptance, the block SHALL compute and register the parity bit as (XOR of all DATA_W bits of in_data) XOR odd_sel.
REQ-009 odd_sel SHALL be sampled only at acceptance; changes during a frame SHALL have no effect on that frame.
REQ-010 Transitions SHALL be:
- IDLE -> SHIFT on acceptance.
- SHIFT -> PARITY after DATA_W bits have been output.
- PARITY -> SHIFT on acceptance in that cycle; otherwise PARITY -> IDLE.
REQ-011 In SHIFT, the block SHALL output the captured bits LSB first, one per cycle, with ser_valid=1 and ser_is_par=0.
REQ-012 The first data bit SHALL appear in the cycle immediately after the acceptance edge (latency 1 cycle).
REQ-013 The bit counter SHALL be $clog2(DATA_W) bits wide.
REQ-014 The bit counter SHALL run from 0 to DATA_W-1 and SHALL NOT wrap within a frame.
REQ-015 In PARITY, ser_out SHALL equal the registered parity bit, with ser_valid=1, ser_is_par=1 and frame_done=1.
REQ-016 A frame SHALL occupy exactly DATA_W+1 consecutive ser_valid cycles.
REQ-017 Back-to-back frames (acceptance during PARITY) SHALL run with no idle gap, giving a throughput of one word per DATA_W+1 cycles.
REQ-018 In IDLE, outputs SHALL be ser_out=1 (idle mark), ser_valid=0, ser_is_par=0 and frame_done=0.
REQ-019 in_valid asserted while in_ready=0 SHALL be ignored, with no capture and no state change; the upstream holds the word until accepted.
REQ-020 frame_done SHALL never be asserted outside PARITY.
REQ-021 The block SHALL NOT emit partial frames except when truncated by reset (REQ-023).

Reset
REQ-022 While rst_n=0, outputs SHALL be:
- state = IDLE.
- in_ready = 1.
- ser_out = 1, ser_valid = 0, ser_is_par = 0, frame_done = 0.
- shift register, bit counter and parity register = 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously), with no further frame bits output.
REQ-024 After rst_n deasserts, the first accepted word SHALL start a complete new frame.

Verification
REQ-025 The bench SHALL cover these scenarios (DATA_W=8):
- in_data=0xA5, odd_sel=0 -> ser_out 1,0,1,0,0,1,0,1 then parity 0; frame_done high only on cycle 9.
- in_data=0xA5, odd_sel=1 -> same data bits, then parity 1.
- in_data=0x07, odd_sel=0 -> bits 1,1,1,0,0,0,0,0 then parity 1.
- Back-to-back: 0x01 then 0xFF, with the second word presented during PARITY -> 18 contiguous ser_valid cycles; parities 1 then 0; in_ready low during both SHIFT phases.
- in_valid held high during SHIFT with changing in_data and odd_sel -> no capture; the current frame is unaltered.
- rst_n pulsed low at bit 4 of a frame -> ser_valid=0 and ser_out=1 immediately; a subsequent 0x00 (even) produces 8 zeros then parity 0.
REQ-026 The bench SHALL repeat the parity checks at DATA_W=2 and DATA_W=32 against a reference XOR model.

Source files
------------

// File: rtl/par_frame_gen.sv
// par_frame_gen: accepts one DATA_W-bit word at a time and emits it as a
// serial frame, data bits LSB first followed by one parity bit. Parity mode
// (even/odd) is chosen per word. A new word may be accepted in the
// parity cycle, so frames can run back to back with no idle gap.
module par_frame_gen #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              odd_sel,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_is_par,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shift_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              par_bit;
    logic              accept;

    // in_ready depends on state only, so this has no combinational path
    // from in_valid back to in_ready.
    assign accept = in_valid && in_ready;

    // State register; reset forces IDLE at once, so outputs go to idle mark
    // asynchronously and any frame in flight is dropped.
    // NOTE: sequential state uses non-blocking (<=) so all flops update
    // together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and Moore outputs.
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        ser_out    = 1'b1;
        ser_valid  = 1'b0;
        ser_is_par = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                ser_out   = shift_reg[0];
                ser_valid = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    state_nxt = PARITY;
                end
            end
            PARITY: begin
                in_ready   = 1'b1;
                ser_out    = par_bit;
                ser_valid  = 1'b1;
                ser_is_par = 1'b1;
                frame_done = 1'b1;
                state_nxt  = in_valid ? SHIFT : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture word and parity on acceptance, then shift right one
    // bit per SHIFT cycle while the counter walks 0..DATA_W-1 without wrap.
    // NOTE: these are plain registers, not a memory array, so they take an
    // async reset to a known zero like the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
        end else if (accept) begin
            shift_reg <= in_data;
            bit_cnt   <= '0;
            par_bit   <= (^in_data) ^ odd_sel;
        end else if (state == SHIFT) begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt != LAST_BIT) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_par_frame_gen.sv
// Self-checking bench for par_frame_gen. The DATA_W=8 instance is checked
// through a scoreboard of expected serial bits filled when each word is
// accepted; DATA_W=2 and DATA_W=32 instances are checked against a
// reference XOR parity model.
module tb_par_frame_gen;

    logic clk;
    logic rst_n;

    // DATA_W = 8 instance
    logic       v8, rdy8, o8, ser8, sv8, par8, done8;
    logic [7:0] d8;
    // DATA_W = 2 instance
    logic       v2, rdy2, o2, ser2, sv2, par2, done2;
    logic [1:0] d2;
    // DATA_W = 32 instance
    logic        v32, rdy32, o32, ser32, sv32, par32, done32;
    logic [31:0] d32;

    int checks   = 0;
    int failures = 0;
    int streak      = 0;
    int last_streak = 0;

    typedef struct packed {
        logic ser;
        logic par;
        logic done;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       odd;
        logic [7:0] seq;   // seq[i] is the i-th serial data bit
        logic       par;
    } vec8_t;

    par_frame_gen #(.DATA_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
        .in_data(d8), .odd_sel(o8), .ser_out(ser8), .ser_valid(sv8),
        .ser_is_par(par8), .frame_done(done8)
    );

    par_frame_gen #(.DATA_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
        .in_data(d2), .odd_sel(o2), .ser_out(ser2), .ser_valid(sv2),
        .ser_is_par(par2), .frame_done(done2)
    );

    par_frame_gen #(.DATA_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32),
        .in_data(d32), .odd_sel(o32), .ser_out(ser32), .ser_valid(sv32),
        .ser_is_par(par32), .frame_done(done32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_par(input logic [31:0] d, input int w, input logic o);
        logic p;
        p = o;
        for (int i = 0; i < w; i++) p = p ^ d[i];
        return p;
    endfunction

    // Scoreboard monitor for the 8-bit instance, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", rdy8, !(sv8 && !par8));
            if (sv8) begin
                streak++;
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", sv8, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ser_out", ser8, e.ser);
                    check("ser_is_par", par8, e.par);
                    check("frame_done", done8, e.done);
                end
            end else begin
                if (streak != 0) last_streak = streak;
                streak = 0;
                check("idle_out", {ser8, par8, done8}, 3'b100);
            end
        end
    end

    // Present a word on the 8-bit instance, hold until accepted, and queue
    // its expected frame at the acceptance edge.
    task automatic send8(input logic [7:0] d, input logic o,
                         input logic [7:0] seq, input logic par);
        int n;
        n = 0;
        v8 = 1'b1;
        d8 = d;
        o8 = o;
        while (!rdy8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy8) begin
            check("accept_timeout", rdy8, 1'b1);
        end else begin
            for (int i = 0; i < 8; i++) exp_q.push_back('{ser: seq[i], par: 1'b0, done: 1'b0});
            exp_q.push_back('{ser: par, par: 1'b1, done: 1'b1});
        end
        @(posedge clk);
        #1;
        v8 = 1'b0;
    endtask

    task automatic drain8();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
        #1;
    endtask

    function automatic logic [3:0] wide_out(input int w);
        if (w == 2) return {sv2, par2, done2, ser2};
        return {sv32, par32, done32, ser32};
    endfunction

    // One frame on the 2- or 32-bit instance, checked bit by bit.
    task automatic run_wide(input int w, input logic [31:0] d, input logic o);
        logic p;
        p = ref_par(d, w, o);
        @(negedge clk);
        if (w == 2) begin
            v2 = 1'b1; d2 = d[1:0]; o2 = o;
        end else begin
            v32 = 1'b1; d32 = d; o32 = o;
        end
        @(posedge clk);
        #1;
        v2  = 1'b0;
        v32 = 1'b0;
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            check($sformatf("w%0d_bit%0d", w, i), wide_out(w), {3'b100, d[i]});
        end
        @(negedge clk);
        check($sformatf("w%0d_parity_%0h", w, d), wide_out(w), {3'b111, p});
    endtask

    vec8_t vecs[4];

    initial begin
        vecs[0] = '{data: 8'hA5, odd: 1'b0, seq: 8'b10100101, par: 1'b0};
        vecs[1] = '{data: 8'hA5, odd: 1'b1, seq: 8'b10100101, par: 1'b1};
        vecs[2] = '{data: 8'h07, odd: 1'b0, seq: 8'b00000111, par: 1'b1};
        vecs[3] = '{data: 8'h80, odd: 1'b1, seq: 8'b10000000, par: 1'b0};

        rst_n = 1'b0;
        v8 = 0; d8 = '0; o8 = 0;
        v2 = 0; d2 = '0; o2 = 0;
        v32 = 0; d32 = '0; o32 = 0;

        // Reset values
        #23;
        check("rst_outputs", {rdy8, ser8, sv8, par8, done8}, 5'b11000);
        check("rst_state", u8.state, 0);
        check("rst_regs", {u8.shift_reg, u8.bit_cnt, u8.par_bit}, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Single frames from the table
        foreach (vecs[i]) begin
            send8(vecs[i].data, vecs[i].odd, vecs[i].seq, vecs[i].par);
            drain8();
        end

        // Back-to-back: second word taken during the first frame's parity
        send8(8'h01, 1'b0, 8'b00000001, 1'b1);
        send8(8'hFF, 1'b0, 8'b11111111, 1'b0);
        drain8();
        check("b2b_streak", last_streak, 18);

        // in_valid held with changing data during SHIFT is ignored
        send8(8'h3C, 1'b1, 8'b00111100, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            v8 = 1'b1;
            d8 = 8'($urandom);
            o8 = ~o8;
        end
        @(posedge clk);
        #1;
        v8 = 1'b0;
        drain8();

        // Reset pulsed while bit 4 of a frame is on the line
        send8(8'hC3, 1'b0, 8'b11000011, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out", {rdy8, ser8, sv8, par8, done8}, 5'b11000);
        check("rst_mid_cnt", u8.bit_cnt, 0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        send8(8'h00, 1'b0, 8'b00000000, 1'b0);
        drain8();

        // Parity at other widths against the reference model
        run_wide(2, 32'h0, 1'b0);
        run_wide(2, 32'h1, 1'b0);
        run_wide(2, 32'h3, 1'b1);
        run_wide(2, 32'h2, 1'b1);
        run_wide(32, 32'hDEADBEEF, 1'b0);
        run_wide(32, 32'h80000001, 1'b1);
        run_wide(32, 32'hFFFFFFFF, 1'b0);
        for (int i = 0; i < 3; i++) run_wide(32, $urandom, 1'($urandom));

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
